// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: quadrant type, octant-to-quadrant map and the
// quarter-turn phase constant used by the pre-rotation and upconverter stages.
package cordic_pkg;

  typedef logic [1:0] quad_t;

  localparam quad_t QUAD_0 = 2'd0;
  localparam quad_t QUAD_1 = 2'd1;
  localparam quad_t QUAD_2 = 2'd2;
  localparam quad_t QUAD_3 = 2'd3;

  // Entry for octant t sits at bits [2t+1:2t]; octants 7 and 0 both map to quadrant 0.
  localparam logic [15:0] OCT_TO_QUAD = {QUAD_0, QUAD_3, QUAD_3, QUAD_2,
                                         QUAD_2, QUAD_1, QUAD_1, QUAD_0};

  function automatic logic [63:0] quarter(input int pw);
    return 64'd1 << (pw - 2);
  endfunction

endpackage

// File: rtl/cordic_quad_rotate.sv
// Combinational octant decode: picks the quadrant, the swap/negate controls for
// the (a,b) datapath and the residual phase left after removing quad quarter turns.
module cordic_quad_rotate
  import cordic_pkg::*;
#(
  parameter int PW = 20
) (
  input  logic [PW-1:0] i_phase,
  output quad_t         o_quad,
  output logic          o_swap,
  output logic          o_neg_a,
  output logic          o_neg_b,
  output logic [PW-1:0] o_phase
);

  localparam logic [PW-1:0] Q = PW'(quarter(PW));

  logic [2:0] oct;
  assign oct = i_phase[PW-1 -: 3];

  // Quadrant k means a = swap ? b_in : a_in, then (neg_a, neg_b) applied.
  always_comb begin
    o_quad  = OCT_TO_QUAD[{oct, 1'b0} +: 2];
    o_swap  = o_quad[0];
    o_neg_a = (o_quad == QUAD_1) || (o_quad == QUAD_2);
    o_neg_b = (o_quad == QUAD_2) || (o_quad == QUAD_3);
    o_phase = i_phase - (PW'(o_quad) * Q);
  end

endmodule

// File: rtl/cordic_pre_rotate_mc.sv
// Multi-channel CORDIC pre-rotation: adds a per-channel phase offset, then folds
// the sample into +/-45 degrees by a quadrant rotation. Offset table only with CORDIC_PREROT_OFFSET_EN.
module cordic_pre_rotate_mc
  import cordic_pkg::*;
#(
  parameter  int IW  = 13,
  parameter  int WW  = 16,
  parameter  int PW  = 20,
  parameter  int NCH = 4,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [IW-1:0] i_xval,
  input  logic [IW-1:0] i_yval,
  input  logic [PW-1:0] i_phase,
  input  logic [CW-1:0] i_ch,
  input  logic          i_cfg_we,
  input  logic [CW-1:0] i_cfg_ch,
  input  logic [PW-1:0] i_cfg_offset,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [WW-1:0] o_xval,
  output logic [WW-1:0] o_yval,
  output logic [PW-1:0] o_phase,
  output quad_t         o_quad,
  output logic [CW-1:0] o_ch
);

  localparam int PAD = WW - IW - 1;

  logic          v1_reg, v2_reg;
  logic          adv1, adv2;
  logic [WW-1:0] x1_reg, y1_reg;
  logic [PW-1:0] p1_reg;
  logic [CW-1:0] ch1_reg;
  logic [WW-1:0] x_ext, y_ext;
  logic [PW-1:0] offset_sel;

  logic [WW-1:0] xo_reg, yo_reg;
  logic [PW-1:0] po_reg;
  quad_t         qo_reg;
  logic [CW-1:0] cho_reg;

`ifdef CORDIC_PREROT_OFFSET_EN
  logic [PW-1:0] offset_reg [NCH];

  // Writes to channels >= NCH never match an entry and are dropped.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (i_reset)
        offset_reg[i] <= '0;
      else if (i_cfg_we && i_cfg_ch == CW'(i))
        offset_reg[i] <= i_cfg_offset;
    end
  end

  always_comb begin
    offset_sel = '0;
    for (int i = 0; i < NCH; i++)
      if (i_ch == CW'(i)) offset_sel = offset_reg[i];
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{i_cfg_we, i_cfg_ch, i_cfg_offset};
  assign offset_sel = '0;
`endif

  assign adv2    = !v2_reg || i_ready;
  assign adv1    = !v1_reg || adv2;
  assign o_ready = adv1;

  // Sign-extend then shift: {sign, value, PAD zeros} leaves one bit of headroom.
  assign x_ext = {{(WW-IW){i_xval[IW-1]}}, i_xval} << PAD;
  assign y_ext = {{(WW-IW){i_yval[IW-1]}}, i_yval} << PAD;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      v1_reg  <= 1'b0;
      x1_reg  <= '0;
      y1_reg  <= '0;
      p1_reg  <= '0;
      ch1_reg <= '0;
    end else if (adv1) begin
      v1_reg <= i_valid;
      if (i_valid) begin
        x1_reg  <= x_ext;
        y1_reg  <= y_ext;
        p1_reg  <= i_phase + offset_sel;
        ch1_reg <= i_ch;
      end
    end
  end

  quad_t         rot_quad;
  logic          rot_swap, rot_neg_a, rot_neg_b;
  logic [PW-1:0] rot_phase;
  logic [WW-1:0] rot_a, rot_b, rot_x, rot_y;

  cordic_quad_rotate #(.PW(PW)) u_rotate (
    .i_phase (p1_reg),
    .o_quad  (rot_quad),
    .o_swap  (rot_swap),
    .o_neg_a (rot_neg_a),
    .o_neg_b (rot_neg_b),
    .o_phase (rot_phase)
  );

  assign rot_a = rot_swap ? y1_reg : x1_reg;
  assign rot_b = rot_swap ? x1_reg : y1_reg;
  assign rot_x = rot_neg_a ? -rot_a : rot_a;
  assign rot_y = rot_neg_b ? -rot_b : rot_b;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      v2_reg  <= 1'b0;
      xo_reg  <= '0;
      yo_reg  <= '0;
      po_reg  <= '0;
      qo_reg  <= QUAD_0;
      cho_reg <= '0;
    end else if (adv2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        xo_reg  <= rot_x;
        yo_reg  <= rot_y;
        po_reg  <= rot_phase;
        qo_reg  <= rot_quad;
        cho_reg <= ch1_reg;
      end
    end
  end

  assign o_valid = v2_reg;
  assign o_xval  = xo_reg;
  assign o_yval  = yo_reg;
  assign o_phase = po_reg;
  assign o_quad  = qo_reg;
  assign o_ch    = cho_reg;

endmodule

// File: doc/cordic_pre_rotate_mc.md
CORDIC_PRE_ROTATE_MC -- requirements
Module: cordic_pre_rotate_mc

Interface
REQ-001 SHALL have parameter IW, default 13: input sample width, signed.
REQ-002 SHALL have parameter WW, default 16: working/output width, signed, with WW >= IW+1.
REQ-003 SHALL have parameter PW, default 20: phase width, unsigned, with PW >= 4.
REQ-004 SHALL have parameter NCH, default 4: channel count; CW = max(1, clog2(NCH)).
REQ-005 SHALL have port i_clk  in  1: the single clock.
REQ-006 SHALL have port i_reset  in  1: synchronous, active-high reset.
REQ-007 SHALL have ports i_valid in 1 and o_ready out 1: input handshake.
REQ-008 SHALL have ports i_xval in IW and i_yval in IW: signed input sample.
REQ-009 SHALL have ports i_phase in PW and i_ch in CW: sample phase and channel tag.
REQ-010 SHALL have ports i_cfg_we in 1, i_cfg_ch in CW and i_cfg_offset in PW: per-channel phase-offset write.
REQ-011 SHALL have ports o_valid out 1 and i_ready in 1: output handshake.
REQ-012 SHALL have ports o_xval out WW, o_yval out WW, o_phase out PW, o_quad out 2 and o_ch out CW.

Function
REQ-013 SHALL accept a sample in any cycle where i_valid && o_ready, and emit it on a cycle where o_valid && i_ready.
REQ-014 SHALL use a two-stage pipeline with latency exactly 2 cycles when the output is not stalled.
  - S1: extend inputs, add the offset, register the channel.
  - S2: rotate, register the outputs.
REQ-015 SHALL advance each stage when it is empty or its successor advances: adv2 = !v2 || i_ready; adv1 = !v1 || adv2; o_ready = adv1 (combinational).
REQ-016 SHALL hold all outputs stable while o_valid && !i_ready.
REQ-017 SHALL preserve sample order, with no loss or duplication.
REQ-018 SHALL extend each input as {sign, value, (WW-IW-1) zeros}, giving one bit of headroom so that negation never overflows.
REQ-019 SHALL compute the S1 phase p = i_phase + offset[i_ch] modulo 2^PW, wrapping silently.
REQ-020 SHALL select the rotation from top three bits T = p[PW-1:PW-3], with Q = 2^(PW-2):
  - T 000/111: quad 0, (x,y), phase p.
  - T 001/010: quad 1, (-y,x), phase p-Q.
  - T 011/100: quad 2, (-x,-y), phase p-2Q.
  - T 101/110: quad 3, (y,-x), phase p-3Q.
  - All phase results SHALL be modulo 2^PW.
REQ-021 SHALL produce an o_phase that, read as signed, lies in [-2^(PW-3), 2^(PW-3)).
REQ-022 SHALL make o_ch equal the i_ch accepted with that sample.
REQ-023 SHALL apply an offset write in cycle n only to samples accepted after cycle n.
  - A sample accepted in cycle n SHALL use the old offset.
REQ-024 SHALL accept an offset write in any cycle, independent of backpressure.
REQ-025 SHALL ignore a write whose i_cfg_ch >= NCH; samples with i_ch >= NCH SHALL use offset 0.

Reset
REQ-026 SHALL, on i_reset in cycle n, zero from cycle n+1: both stage valids, o_valid, o_xval, o_yval, o_phase, o_quad, o_ch and all offsets.
REQ-027 SHALL discard in-flight samples on reset mid-operation, emitting none afterwards.
REQ-028 SHALL give i_reset priority over a simultaneous handshake or offset write.
REQ-029 SHALL drive o_ready high in the first cycle after reset.

Configuration
REQ-030 SHALL, with macro CORDIC_PREROT_OFFSET_EN defined, implement the NCH x PW offset table as specified.
REQ-031 SHALL, without CORDIC_PREROT_OFFSET_EN, treat every offset as 0, ignore the i_cfg_* ports and instantiate no table registers, with latency unchanged.

Structure
REQ-032 SHALL take from a shared package cordic_pkg:
  - quadrant-constant function quarter(PW) = 2^(PW-2);
  - quad_t 2-bit typedef;
  - octant-to-quadrant mapping constants.
REQ-033 SHALL implement the rotate mux as one sub-module, cordic_quad_rotate, a combinational T-to-(swap, negate, phase) mapping that is reusable by the upconverter.

Verification (IW=13, WW=16, PW=20, NCH=4)
REQ-034 SHALL cover: x=256, y=0, phase 0x30000, ch0, offset 0 -> 2 cycles later o_xval=0, o_yval=1024, o_phase=0xF0000, o_quad=1.
REQ-035 SHALL cover: offset[2]=0x40000, then phase 0x10000 on ch2 -> o_phase=0x10000, o_quad=1; same phase on ch1 -> o_quad=0.
REQ-036 SHALL cover wrap: offset[3]=0x20000, phase 0xF0000 on ch3 -> p=0x10000, o_quad=0, o_phase=0x10000.
REQ-037 SHALL cover headroom: x=-4096, y=0, phase 0x80000 -> o_xval=+16384, o_yval=0, o_quad=2, o_phase=0x00000.
REQ-038 SHALL cover backpressure: continuous i_valid, i_ready low for 5 cycles -> o_ready low after 2 accepted, outputs stable, all samples later emitted in order.
REQ-039 SHALL cover reset mid-stream: reset with v1=v2=1 -> no o_valid until new input, offsets read 0; build without CORDIC_PREROT_OFFSET_EN -> REQ-035 gives o_quad=0 on ch2.
